// File: rtl/shift_sequencer.sv
// Multi-cycle controller that drives a single-step shifter to perform
// shifts of 0..2^AMT_W-1 positions, with a start/done handshake.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [1:0]       MODE,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [WIDTH-1:0] SH_RESULT,
    output logic [WIDTH-1:0] SH_DATA,
    output logic [1:0]       SH_SEL,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [AMT_W-1:0] cnt_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic             busy_q;
    logic [1:0]       sel_q;

    // Outputs are registered alongside the state so they change only on
    // state transitions; each branch sets the values for the state it enters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and ordering inside the block is irrelevant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            work_q   <= '0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        work_q <= DATA_IN;
                        mode_q <= MODE;
                        cnt_q  <= AMT;
                        busy_q <= 1'b1;
                        if (AMT == '0 || MODE == 2'b00) begin
                            state_q  <= FINISH;
                            done_q   <= 1'b1;
                            result_q <= DATA_IN;
                            sel_q    <= 2'b00;
                        end else begin
                            state_q <= SHIFT;
                            sel_q   <= MODE;
                        end
                    end
                end

                SHIFT: begin
                    // Abort wins over the last step's transition into FINISH.
                    if (ABORT) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        sel_q   <= 2'b00;
                    end else begin
                        work_q <= SH_RESULT;
                        cnt_q  <= cnt_q - AMT_W'(1);
                        if (cnt_q == AMT_W'(1)) begin
                            state_q  <= FINISH;
                            done_q   <= 1'b1;
                            result_q <= SH_RESULT;
                            sel_q    <= 2'b00;
                        end
                    end
                end

                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    sel_q   <= 2'b00;
                end

                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    sel_q   <= 2'b00;
                end
            endcase
        end
    end

    assign SH_DATA = work_q;
    assign SH_SEL  = sel_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RESULT  = result_q;

endmodule
